// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared encodings for the iterative RV32M unit.
// Holds funct3 codes, FSM states, width defaults, sign helpers.
package ex_muldiv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int MUL_K_DEF = 4;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic rs1_signed(
    input logic [2:0] op
  );
    return op inside {OP_MULH, OP_MULHSU,
                      OP_DIV, OP_REM};
  endfunction

  function automatic logic rs2_signed(
    input logic [2:0] op
  );
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// ex_muldiv_div_iter: one restoring-divide step.
// In: rem_in, bit_in, dvs_in. Out: rem_out, q_out.
module ex_muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] dvs_in,
  output logic [XLEN-1:0] rem_out,
  output logic            q_out
);

  // Shifted partial remainder can need one extra bit
  // when the divisor has its MSB set.
  logic [XLEN:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_out   = shifted >= {1'b0, dvs_in};

  assign rem_out = q_out
    ? XLEN'(shifted - {1'b0, dvs_in})
    : shifted[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide beside the EX ALU.
// Ports: clk/rst/rdy/flush, start+op+operands+rd in; stall, valid, result, rd out.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int MUL_K = MUL_K_DEF
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            flush_in,
  input  logic            start_in,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] rs1_val_in,
  input  logic [XLEN-1:0] rs2_val_in,
  input  logic [4:0]      rd_addr_in,
  output logic            stallreq_out,
  output logic            valid_out,
  output logic [XLEN-1:0] rd_val_out,
  output logic [4:0]      rd_addr_out
);

  localparam int CW    = $clog2(XLEN) + 1;
  localparam int MUL_N = XLEN / MUL_K;
  localparam int PW    = 2 * XLEN;

  localparam logic [CW-1:0] MUL_LAST =
    CW'(MUL_N - 1);
  localparam logic [CW-1:0] DIV_LAST =
    CW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN =
    {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;

  // Start decode
  logic            rs1_neg, rs2_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    rs1_neg  = rs1_signed(op_in)
             & rs1_val_in[XLEN-1];
    rs2_neg  = rs2_signed(op_in)
             & rs2_val_in[XLEN-1];
    a_mag    = rs1_neg ? -rs1_val_in
                       : rs1_val_in;
    b_mag    = rs2_neg ? -rs2_val_in
                       : rs2_val_in;
    div_zero = op_in[2]
             & (rs2_val_in == '0);
    div_ovf  = (op_in == OP_DIV ||
                op_in == OP_REM)
             && rs1_val_in == XMIN
             && rs2_val_in == '1;
    special  = div_zero | div_ovf;
    // op_in[1] selects the remainder
    if (div_zero)
      spec_res = op_in[1] ? rs1_val_in : '1;
    else
      spec_res = op_in[1] ? '0 : rs1_val_in;
  end

  // Multiply step: MUL_K partial products
  logic [PW-1:0]   pp_sum, acc_nx, prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < MUL_K; i++) begin
      if (mplier_q[i])
        pp_sum = pp_sum + (mcand_q << i);
    end
    acc_nx  = acc_q + pp_sum;
    prod    = neg_q ? -acc_nx : acc_nx;
    mul_res = (op_q == OP_MUL)
            ? prod[XLEN-1:0]
            : prod[PW-1:XLEN];
  end

  // Divide step: dividend shifts out of quo_q
  // while quotient bits shift in behind it.
  logic [XLEN-1:0] rem_nx, q_fin, r_fin;
  logic [XLEN-1:0] div_res;
  logic            q_bit;

  ex_muldiv_div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .rem_in (rem_q),
    .bit_in (quo_q[XLEN-1]),
    .dvs_in (dvs_q),
    .rem_out(rem_nx),
    .q_out  (q_bit)
  );

  always_comb begin
    q_fin   = {quo_q[XLEN-2:0], q_bit};
    r_fin   = rneg_q ? -rem_nx : rem_nx;
    div_res = op_q[1] ? r_fin
            : (neg_q ? -q_fin : q_fin);
  end

  logic mul_last, div_last;

  assign mul_last = cnt_q == MUL_LAST;
  assign div_last = cnt_q == DIV_LAST;

  // FSM: state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      state_q <= S_IDLE;
    else if (rdy_in)
      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_in)
          state_d = special  ? S_DONE
                  : op_in[2] ? S_DIV
                             : S_MUL;
        S_MUL: if (mul_last)
          state_d = S_DONE;
        S_DIV: if (div_last)
          state_d = S_DONE;
        S_DONE:
          state_d = S_IDLE;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    stallreq_out = 1'b0;
    valid_out    = 1'b0;
    unique case (state_q)
      S_IDLE: stallreq_out = start_in
                           & ~flush_in;
      S_MUL:  stallreq_out = 1'b1;
      S_DIV:  stallreq_out = 1'b1;
      S_DONE: valid_out    = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    op_d     = op_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    if (!flush_in) begin
      unique case (state_q)
        S_IDLE: if (start_in) begin
          op_d     = op_in;
          rd_d     = rd_addr_in;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, a_mag};
          mplier_d = b_mag;
          rem_d    = '0;
          quo_d    = a_mag;
          dvs_d    = b_mag;
          neg_d    = rs1_neg ^ rs2_neg;
          rneg_d   = rs1_neg;
          if (special)
            res_d = spec_res;
        end
        S_MUL: begin
          acc_d    = acc_nx;
          mcand_d  = mcand_q << MUL_K;
          mplier_d = mplier_q >> MUL_K;
          cnt_d    = cnt_q + CW'(1);
          if (mul_last)
            res_d = mul_res;
        end
        S_DIV: begin
          rem_d = rem_nx;
          quo_d = q_fin;
          cnt_d = cnt_q + CW'(1);
          if (div_last)
            res_d = div_res;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      op_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else if (rdy_in) begin
      op_q     <= op_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign rd_val_out  = res_q;
  assign rd_addr_out = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv.
// Arithmetic reference model, queued expectations, decoupled monitor.
module tb_ex_muldiv;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy   = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = '0;
  logic [31:0] rs1   = '0;
  logic [31:0] rs2   = '0;
  logic [4:0]  rd    = '0;
  logic        stall, valid;
  logic [31:0] res;
  logic [4:0]  rd_o;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          t0;
    int          lat;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  string op_name [8] = '{"MUL", "MULH",
    "MULHSU", "MULHU", "DIV", "DIVU",
    "REM", "REMU"};

  ex_muldiv #(
    .XLEN (32),
    .MUL_K(4)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .rdy_in      (rdy),
    .flush_in    (flush),
    .start_in    (start),
    .op_in       (op),
    .rs1_val_in  (rs1),
    .rs2_val_in  (rs2),
    .rd_addr_in  (rd),
    .stallreq_out(stall),
    .valid_out   (valid),
    .rd_val_out  (res),
    .rd_addr_out (rd_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] want
  );
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               name, act, want);
    end
  endtask

  // Reference: plain 64-bit arithmetic on
  // sign- or zero-extended operands.
  function automatic exp_t model(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  r
  );
    exp_t        e;
    logic [63:0] sa, sb, ua, ub, p;
    int          ia, ib;
    logic        dz, ov;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    dz = (b == 0);
    ov = (a == 32'h8000_0000) && (ib == -1);
    p  = '0;
    case (o)
      3'd0: begin p = sa * sb; e.res = p[31:0]; end
      3'd1: begin p = sa * sb; e.res = p[63:32]; end
      3'd2: begin p = sa * ub; e.res = p[63:32]; end
      3'd3: begin p = ua * ub; e.res = p[63:32]; end
      3'd4: e.res = dz ? 32'hFFFF_FFFF
                  : ov ? a : 32'(ia / ib);
      3'd5: e.res = dz ? 32'hFFFF_FFFF : a / b;
      3'd6: e.res = dz ? a
                  : ov ? 32'd0 : 32'(ia % ib);
      default: e.res = dz ? a : a % b;
    endcase
    if (o < 4)
      e.lat = 9;
    else if (dz || (ov && o inside {3'd4, 3'd6}))
      e.lat = 1;
    else
      e.lat = 33;
    e.rd   = r;
    e.t0   = 0;
    e.name = op_name[o];
    return e;
  endfunction

  // Monitor: pops one expectation per delivered result
  always @(negedge clk) begin
    if (rst_n && valid && rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got res %h rd %0d want no result",
                 res, rd_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_res"}, res, mon_e.res);
        chk({mon_e.name, "_rd"}, 32'(rd_o),
            32'(mon_e.rd));
        chk({mon_e.name, "_lat"},
            32'(cyc - mon_e.t0), 32'(mon_e.lat));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  r,
    input bit          want_result
  );
    exp_t e;
    op    = o;
    rs1   = a;
    rs2   = b;
    rd    = r;
    start = 1'b1;
    if (want_result) begin
      e    = model(o, a, b, r);
      e.t0 = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d outstanding after %0d cycles, want 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic run_op(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  r
  );
    issue(o, a, b, r, 1'b1);
    step();
    start = 1'b0;
    wait_done(60);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  logic [2:0]  d_op [11] = '{3'd1, 3'd3, 3'd2,
    3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6,
    3'd4, 3'd6};
  logic [31:0] d_a [11] = '{32'h8000_0000,
    32'hFFFF_FFFF, 32'hFFFF_FFFF,
    32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
    32'd100, 32'd5, 32'd5, 32'h8000_0000,
    32'h8000_0000};
  logic [31:0] d_b [11] = '{32'h8000_0000,
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
    32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
    32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // MUL 7 x -3 with stall profile
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("mul_stall", 32'(stall), 32'(k < 9));
      step();
      start = 1'b0;
    end

    for (int i = 0; i < 11; i++)
      run_op(d_op[i], d_a[i], d_b[i], 5'(i + 1));

    // Flush a DIV in its cycle 10
    issue(3'd4, 32'd1000, 32'd3, 5'd20, 1'b0);
    step();
    start = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_valid", 32'(valid), 32'd0);
    run_op(3'd0, 32'd6, 32'd7, 5'd9);

    // Reset in cycle 4 of a MUL
    issue(3'd0, 32'h1234, 32'h55, 5'd17, 1'b0);
    step();
    start = 1'b0;
    repeat (3) step();
    chk("pre_rst_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_res", res, 32'd0);
    chk("mid_rst_rd", 32'(rd_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Five not-ready cycles inside a MUL
    issue(3'd1, 32'hFFFF_FF00, 32'h0001_2345,
          5'd30, 1'b1);
    exp_q[0].lat = 14;
    step();
    start = 1'b0;
    step();
    step();
    rdy = 1'b0;
    repeat (5) step();
    rdy = 1'b1;
    wait_done(60);

    // Random back-to-back traffic
    for (int i = 0; i < 80; i++)
      run_op(3'($urandom_range(0, 7)),
             rnd_opnd(), rnd_opnd(),
             5'($urandom_range(0, 31)));

    repeat (3) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d queued, want 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide execute unit with a parametrised datapath width and multiply radix. It sits beside the single-cycle EX ALU. It accepts one M-extension operation at a time from the ID/EX register and raises a stall request while it iterates. It delivers the result, together with its destination register, for exactly one cycle to the EX/MEM path.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; must be a multiple of `MUL_K` and at least 8.
- `MUL_K`, 4: multiplier bits retired per cycle; must divide `XLEN`.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: global ready. While low, all state, counters and outputs hold.
- `flush_in` in 1: synchronous cancel, from a branch taken in EX.
- `start_in` in 1: request a new operation. Sampled only in IDLE.
- `op_in` in 3: funct3 code. MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `rs1_val_in` in XLEN: first operand.
- `rs2_val_in` in XLEN: second operand.
- `rd_addr_in` in 5: destination register address.
- `stallreq_out` out 1: stall request to the pipeline controller. Combinational.
- `valid_out` out 1: result strobe, high for exactly one cycle.
- `rd_val_out` out XLEN: result.
- `rd_addr_out` out 5: destination register, latched at start.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE with `start_in` and no `flush_in`: latch the operation, the operands and `rd_addr_in`.
  - Divide by zero goes directly to DONE.
  - Signed overflow goes directly to DONE. This is DIV or REM with rs1 = the most negative value and rs2 = all ones.
  - Other op<4 goes to MUL; other op≥4 goes to DIV.
- MUL:
  - Operate on operand magnitudes. rs1 is signed for MULH and MULHSU. rs2 is signed for MULH only.
  - Each cycle adds `MUL_K` partial products into a 2·XLEN accumulator.
  - After XLEN/`MUL_K` iterations, negate the product if the operand signs differ (signed ops only), then go to DONE.
- DIV:
  - Restoring divide on magnitudes, one quotient bit per cycle, XLEN iterations, then go to DONE.
  - Quotient sign is sign(rs1) XOR sign(rs2). Remainder sign is sign(rs1).
- Result selection:
  - MUL gives the product low half.
  - MULH, MULHSU and MULHU give the product high half.
  - DIV and DIVU give the quotient; REM and REMU give the remainder.
- Special results:
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Overflow: quotient = rs1 (most negative value); remainder = 0.
- DONE: `valid_out` = 1 with the registered result, then IDLE on the next enabled edge.
- `stallreq_out` = (IDLE & `start_in` & ~`flush_in`) | MUL | DIV. It is low in DONE, so the instruction advances with its result.
- `start_in` outside IDLE is ignored; the pipeline does not issue while stalled.
- `flush_in`: next state is IDLE from any state. No `valid_out` follows, and the result is discarded. If `flush_in` and `start_in` are both high in IDLE, flush wins.

## Timing
- Reset (asynchronous, `rst_in` low): state = IDLE, `valid_out` = 0, `rd_val_out` = 0, `rd_addr_out` = 0, counters = 0, accumulators = 0. `stallreq_out` = 0 whenever `start_in` = 0.
- Latency L counts cycles from the cycle with `start_in` high to the cycle with `valid_out` high:
  - Special divide cases: L = 1.
  - MUL-class: L = XLEN/`MUL_K` + 1, which is 9 at the defaults.
  - DIV-class: L = XLEN + 1, which is 33 at the defaults.
- Each cycle with `rdy_in` low adds exactly 1 to L. `valid_out` holds high across any such cycle while in DONE.
- The iteration counter is ⌈log2(XLEN)⌉+1 bits wide. It reloads to 0 on every start and never wraps.
- Back-to-back operations: a new start is accepted in the IDLE cycle after DONE. The minimum issue interval is L+1.
- Reset mid-operation aborts at once, with no `valid_out`.

## Structure
- Shared package (`defines.v` style) holds the M-extension funct3 encodings, the state encodings and the XLEN default.
- One sub-module is natural: `div_iter`, one restoring-divide step (remainder, divisor → next remainder, quotient bit).
- Sign fix-up and the multiply accumulator stay in the top level.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `rd_val_out` = 0xFFFFFFEB, `valid_out` at cycle 9; `stallreq_out` high in cycles 0–8.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD at cycle 33. REM of the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same → 0. All at L = 1.
- `flush_in` in cycle 10 of a DIV → `valid_out` never asserts and `stallreq_out` drops in cycle 11. A new MUL started in cycle 11 completes at cycle 20.
- `rst_in` low in cycle 4 of a MUL → all outputs 0 immediately. Separately, `rdy_in` low for 5 cycles during a MUL → `valid_out` at cycle 14 with the correct result.
